// File: rtl/fp_special_case_unit.sv
// Two-stage IEEE-754 special-case resolver for add/sub/mul/div, placed ahead of the arithmetic datapath.
// Optional build macro FP_NAN_PROPAGATE_EN: NaN results carry the first NaN operand (quieted) instead of the canonical NaN.
module fp_special_case_unit #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [1:0]                           in_op,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]        in_a,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]        in_b,
    input  logic [TAG_WIDTH-1:0]                 in_tag,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_special,
    output logic [EXP_WIDTH+MANT_WIDTH:0]        out_result,
    output logic [3:0]                           out_flags,
    output logic [TAG_WIDTH-1:0]                 out_tag,
    input  logic                                 flags_clear,
    output logic [3:0]                           sticky_flags
);

    localparam int W = EXP_WIDTH + MANT_WIDTH + 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic denorm;
        logic zero;
    } class_t;

    localparam logic [EXP_WIDTH-1:0] EXP_ONES  = '1;
    localparam logic [W-1:0]         CANON_NAN = {1'b0, EXP_ONES, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    function automatic class_t classify(input logic [W-1:0] x);
        logic [EXP_WIDTH-1:0]  e;
        logic [MANT_WIDTH-1:0] m;
        class_t                c;
        e        = x[W-2 -: EXP_WIDTH];
        m        = x[MANT_WIDTH-1:0];
        c.nan    = (&e) && (|m);
        c.snan   = c.nan && !m[MANT_WIDTH-1];
        c.inf    = (&e) && !(|m);
        c.denorm = !(|e) && (|m);
        c.zero   = !(|e) && !(|m);
        return c;
    endfunction

    function automatic logic [W-1:0] inf_of(input logic s);
        return {s, EXP_ONES, {MANT_WIDTH{1'b0}}};
    endfunction

    function automatic logic [W-1:0] zero_of(input logic s);
        return {s, {(W-1){1'b0}}};
    endfunction

    // Handshake / advance
    logic adv1;
    logic adv2;
    logic s1_valid;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1 && !rst;

    // Stage 1: operands, op, tag and classification
    op_e                  s1_op;
    logic [W-1:0]         s1_a;
    logic [W-1:0]         s1_b;
    logic [TAG_WIDTH-1:0] s1_tag;
    class_t               s1_cls_a;
    class_t               s1_cls_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: payload registers carry no reset; s1_valid alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_op    <= op_e'(in_op);
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_tag   <= in_tag;
            s1_cls_a <= classify(in_a);
            s1_cls_b <= classify(in_b);
        end
    end

    // Resolution (combinational between S1 and S2)
    logic         sign_a;
    logic         sign_b;
    logic         sign_x;
    logic [W-1:0] b_eff;
    logic [W-1:0] nan_result;
    logic         any_nan;
    logic         res_special;
    logic [W-1:0] res_result;
    logic         res_invalid;
    logic         res_dbz;
    logic [3:0]   res_flags;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        res_special = 1'b1;
        res_result  = '0;
        res_invalid = 1'b0;
        res_dbz     = 1'b0;

        sign_a  = s1_a[W-1];
        sign_b  = s1_b[W-1] ^ (s1_op == OP_SUB);
        sign_x  = sign_a ^ sign_b;
        b_eff   = {sign_b, s1_b[W-2:0]};
        any_nan = s1_cls_a.nan || s1_cls_b.nan;

`ifdef FP_NAN_PROPAGATE_EN
        nan_result                 = s1_cls_a.nan ? s1_a : s1_b;
        nan_result[MANT_WIDTH-1]   = 1'b1;
`else
        nan_result = CANON_NAN;
`endif

        if (any_nan) begin
            res_result  = nan_result;
            res_invalid = s1_cls_a.snan || s1_cls_b.snan;
        end else begin
            case (s1_op)
                OP_ADD, OP_SUB: begin
                    if (s1_cls_a.inf && s1_cls_b.inf && (sign_a != sign_b)) begin
                        res_result  = CANON_NAN;
                        res_invalid = 1'b1;
                    end else if (s1_cls_a.inf) begin
                        res_result = s1_a;
                    end else if (s1_cls_b.inf) begin
                        res_result = b_eff;
                    end else if (s1_cls_a.zero && s1_cls_b.zero) begin
                        res_result = zero_of(sign_a & sign_b);
                    end else if (s1_cls_a.zero) begin
                        res_result = b_eff;
                    end else if (s1_cls_b.zero) begin
                        res_result = s1_a;
                    end else begin
                        res_special = 1'b0;
                    end
                end
                OP_MUL: begin
                    if ((s1_cls_a.inf && s1_cls_b.zero) || (s1_cls_a.zero && s1_cls_b.inf)) begin
                        res_result  = CANON_NAN;
                        res_invalid = 1'b1;
                    end else if (s1_cls_a.inf || s1_cls_b.inf) begin
                        res_result = inf_of(sign_x);
                    end else if (s1_cls_a.zero || s1_cls_b.zero) begin
                        res_result = zero_of(sign_x);
                    end else begin
                        res_special = 1'b0;
                    end
                end
                OP_DIV: begin
                    if ((s1_cls_a.inf && s1_cls_b.inf) || (s1_cls_a.zero && s1_cls_b.zero)) begin
                        res_result  = CANON_NAN;
                        res_invalid = 1'b1;
                    end else if (s1_cls_a.inf) begin
                        res_result = inf_of(sign_x);
                    end else if (s1_cls_b.inf) begin
                        res_result = zero_of(sign_x);
                    end else if (s1_cls_b.zero) begin
                        res_result = inf_of(sign_x);
                        res_dbz    = 1'b1;
                    end else if (s1_cls_a.zero) begin
                        res_result = zero_of(sign_x);
                    end else begin
                        res_special = 1'b0;
                    end
                end
            endcase
        end

        res_flags = {res_invalid, res_dbz, any_nan, s1_cls_a.denorm || s1_cls_b.denorm};
    end

    // Stage 2: registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_special <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            out_tag     <= '0;
        end else if (adv2) begin
            out_valid   <= s1_valid;
            out_special <= s1_valid && res_special;
            out_result  <= s1_valid ? res_result : '0;
            out_flags   <= s1_valid ? res_flags : 4'b0000;
            out_tag     <= s1_valid ? s1_tag : '0;
        end
    end

    // A handshake coinciding with flags_clear still records its flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= 4'b0000;
        end else begin
            sticky_flags <= (flags_clear ? 4'b0000 : sticky_flags)
                          | ((out_valid && out_ready) ? out_flags : 4'b0000);
        end
    end

endmodule

// File: tb/tb_fp_special_case_unit.sv
// Scoreboard bench for fp_special_case_unit: directed cases plus randomized operands against a rule-level model.
module tb_fp_special_case_unit;

    localparam int TW = 4;
    localparam int W  = 32;
    localparam logic [31:0] QNAN_C = 32'h7FC0_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_special;
    logic [W-1:0]  out_result;
    logic [3:0]    out_flags;
    logic [TW-1:0] out_tag;
    logic          flags_clear = 1'b0;
    logic [3:0]    sticky_flags;

    fp_special_case_unit #(.EXP_WIDTH(8), .MANT_WIDTH(23), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_special(out_special),
        .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
        .flags_clear(flags_clear), .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic          special;
        logic [W-1:0]  result;
        logic [3:0]    flags;
    } exp_t;

    typedef enum {C_ZERO, C_DEN, C_NORM, C_INF, C_QNAN, C_SNAN} cat_e;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] sticky_model = 4'b0000;
    int         ready_mode = 1;   // 0: hold low, 1: always high, 2: random

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk(input logic [TW-1:0] tag, input logic special,
                                input logic [31:0] result, input logic [3:0] flags);
        exp_t e;
        e.tag = tag; e.special = special; e.result = result; e.flags = flags;
        return e;
    endfunction

    // Reference model
    function automatic cat_e cat_of(input logic [31:0] x);
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 0) return C_INF;
            return x[22] ? C_QNAN : C_SNAN;
        end
        if (x[30:23] == 8'h00) return (x[22:0] == 0) ? C_ZERO : C_DEN;
        return C_NORM;
    endfunction

    function automatic logic [31:0] nan_pick(input logic [31:0] a, input logic [31:0] b, input cat_e ca);
`ifdef FP_NAN_PROPAGATE_EN
        return ((ca == C_QNAN || ca == C_SNAN) ? a : b) | 32'h0040_0000;
`else
        return QNAN_C;
`endif
    endfunction

    function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [TW-1:0] tag);
        exp_t        r;
        cat_e        ca, cb;
        logic        sa, sb, sx, nan_in;
        logic [31:0] bb;
        ca = cat_of(a);
        cb = cat_of(b);
        sa = a[31];
        sb = (op == 2'b01) ? ~b[31] : b[31];
        bb = {sb, b[30:0]};
        sx = sa ^ sb;
        nan_in = (ca == C_QNAN) || (ca == C_SNAN) || (cb == C_QNAN) || (cb == C_SNAN);
        r = mk(tag, 1'b1, 32'h0, 4'b0000);
        r.flags[1] = nan_in;
        r.flags[0] = (ca == C_DEN) || (cb == C_DEN);
        r.flags[3] = (ca == C_SNAN) || (cb == C_SNAN);
        if (nan_in) begin
            r.result = nan_pick(a, b, ca);
        end else if (op[1] == 1'b0) begin
            if (ca == C_INF && cb == C_INF && sa != sb) begin r.result = QNAN_C; r.flags[3] = 1'b1; end
            else if (ca == C_INF)                       r.result = a;
            else if (cb == C_INF)                       r.result = bb;
            else if (ca == C_ZERO && cb == C_ZERO)      r.result = {sa & sb, 31'b0};
            else if (ca == C_ZERO)                      r.result = bb;
            else if (cb == C_ZERO)                      r.result = a;
            else                                        r.special = 1'b0;
        end else if (op == 2'b10) begin
            if ((ca == C_INF && cb == C_ZERO) || (ca == C_ZERO && cb == C_INF)) begin
                r.result = QNAN_C; r.flags[3] = 1'b1;
            end
            else if (ca == C_INF || cb == C_INF)   r.result = {sx, 8'hFF, 23'b0};
            else if (ca == C_ZERO || cb == C_ZERO) r.result = {sx, 31'b0};
            else                                   r.special = 1'b0;
        end else begin
            if ((ca == C_INF && cb == C_INF) || (ca == C_ZERO && cb == C_ZERO)) begin
                r.result = QNAN_C; r.flags[3] = 1'b1;
            end
            else if (ca == C_INF)  r.result = {sx, 8'hFF, 23'b0};
            else if (cb == C_INF)  r.result = {sx, 31'b0};
            else if (cb == C_ZERO) begin r.result = {sx, 8'hFF, 23'b0}; r.flags[2] = 1'b1; end
            else if (ca == C_ZERO) r.result = {sx, 31'b0};
            else                   r.special = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 7))
            0:       return {s, 31'b0};
            1:       return {s, 8'hFF, 23'b0};
            2:       return {s, 8'hFF, 1'b1, m[21:0]};
            3:       return {s, 8'hFF, 1'b0, m[21:1], 1'b1};
            4:       return {s, 8'h00, m[22:1], 1'b1};
            default: return {s, 8'($urandom_range(1, 254)), m};
        endcase
    endfunction

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0)      out_ready = 1'b0;
            else if (ready_mode == 1) out_ready = 1'b1;
            else                      out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expectations on every output handshake and tracks sticky flags
    initial begin
        exp_t       e;
        logic [3:0] hs;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                sticky_model = 4'b0000;
            end else begin
                hs = 4'b0000;
                check("sticky_flags", sticky_flags, sticky_model);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_output", out_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_tag", out_tag, e.tag);
                        check("out_special", out_special, e.special);
                        check("out_result", out_result, e.result);
                        check("out_flags", out_flags, e.flags);
                        hs = e.flags;
                    end
                end
                sticky_model = (flags_clear ? 4'b0000 : sticky_model) | hs;
            end
        end
    end

    // Offer one op; returns #1 after the accepting edge with in_valid still high.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tag, input exp_t e);
        bit accepted;
        accepted = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                accepted = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) check("in_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        logic [31:0] bp_a[3], bp_b[3];
        logic [1:0]  bp_op[3];
        exp_t        bp_e[3];
        int          accepts, idx;
        bit          seen;

        // Reset
        rst = 1'b1;
        settle(2);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_special", out_special, 1'b0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_flags", out_flags, 4'b0);
        check("rst_out_tag", out_tag, 4'h0);
        check("rst_sticky", sticky_flags, 4'b0);
        check("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        ready_mode = 1;
        settle(2);

        // Latency: inf + -inf
        issue(2'b00, 32'h7F80_0000, 32'hFF80_0000, 4'd3, mk(4'd3, 1'b1, 32'h7FC0_0000, 4'b1000));
        in_valid = 1'b0;
        check("latency_1_cycle", out_valid, 1'b0);
        settle(1);
        check("latency_2_valid", out_valid, 1'b1);
        check("latency_2_tag", out_tag, 4'd3);
        drain();

        // Directed cases, back to back
        issue(2'b11, 32'h3F80_0000, 32'h0000_0000, 4'd4, mk(4'd4, 1'b1, 32'h7F80_0000, 4'b0100));
        issue(2'b11, 32'hBF80_0000, 32'h0000_0000, 4'd5, mk(4'd5, 1'b1, 32'hFF80_0000, 4'b0100));
`ifdef FP_NAN_PROPAGATE_EN
        issue(2'b10, 32'h7F80_0001, 32'h3F80_0000, 4'd6, mk(4'd6, 1'b1, 32'h7FC0_0001, 4'b1010));
`else
        issue(2'b10, 32'h7F80_0001, 32'h3F80_0000, 4'd6, mk(4'd6, 1'b1, 32'h7FC0_0000, 4'b1010));
`endif
        issue(2'b01, 32'h0000_0000, 32'h0000_0000, 4'd7, mk(4'd7, 1'b1, 32'h0000_0000, 4'b0000));
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 4'd8, mk(4'd8, 1'b1, 32'h8000_0000, 4'b0000));
        issue(2'b00, 32'h3F80_0000, 32'h4000_0000, 4'd9, mk(4'd9, 1'b0, 32'h0000_0000, 4'b0000));
        issue(2'b01, 32'h3F80_0000, 32'h7F80_0000, 4'd10, mk(4'd10, 1'b1, 32'hFF80_0000, 4'b0000));
        issue(2'b11, 32'h0000_0001, 32'h8000_0000, 4'd11, mk(4'd11, 1'b1, 32'hFF80_0000, 4'b0101));
        in_valid = 1'b0;
        drain();

        // Backpressure: three back-to-back ops with out_ready held low
        bp_op[0] = 2'b00; bp_a[0] = 32'h3F80_0000; bp_b[0] = 32'h4000_0000; bp_e[0] = mk(4'd1, 1'b0, 32'h0, 4'b0000);
        bp_op[1] = 2'b10; bp_a[1] = 32'h4000_0000; bp_b[1] = 32'hFF80_0000; bp_e[1] = mk(4'd2, 1'b1, 32'hFF80_0000, 4'b0000);
        bp_op[2] = 2'b11; bp_a[2] = 32'h0000_0000; bp_b[2] = 32'h4040_0000; bp_e[2] = mk(4'd3, 1'b1, 32'h0000_0000, 4'b0000);
        ready_mode = 0;
        settle(2);
        accepts = 0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            if (idx < 3) begin
                in_valid = 1'b1; in_op = bp_op[idx]; in_a = bp_a[idx]; in_b = bp_b[idx];
                in_tag = TW'(idx + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_e[idx]);
                idx++;
                accepts++;
            end
            @(posedge clk);
            #1;
        end
        check("bp_accepts", accepts, 2);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_held_valid", out_valid, 1'b1);
        check("bp_held_tag", out_tag, 4'd1);
        ready_mode = 1;
        if (idx == 2) issue(bp_op[2], bp_a[2], bp_b[2], 4'd3, bp_e[2]);
        in_valid = 1'b0;
        drain();

        // Randomized traffic with random backpressure and occasional flag clears
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            a = rand_operand();
            b = rand_operand();
            flags_clear = ($urandom_range(0, 15) == 0);
            issue(op, a, b, TW'(i), ref_model(op, a, b, TW'(i)));
        end
        in_valid = 1'b0;
        flags_clear = 1'b0;
        drain();

        // Sticky: invalid op, then clear coinciding with a div-by-zero handshake
        ready_mode = 1;
        settle(2);
        flags_clear = 1'b1;
        settle(1);
        flags_clear = 1'b0;
        issue(2'b00, 32'h7F80_0000, 32'hFF80_0000, 4'd5, mk(4'd5, 1'b1, 32'h7FC0_0000, 4'b1000));
        in_valid = 1'b0;
        drain();
        settle(1);
        check("sticky_invalid", sticky_flags, 4'b1000);
        issue(2'b11, 32'h3F80_0000, 32'h0000_0000, 4'd6, mk(4'd6, 1'b1, 32'h7F80_0000, 4'b0100));
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            settle(1);
            if (out_valid) begin
                flags_clear = 1'b1;
                seen = 1;
                break;
            end
        end
        check("sticky_out_valid_seen", seen, 1'b1);
        settle(1);
        flags_clear = 1'b0;
        check("sticky_clear_with_handshake", sticky_flags, 4'b0100);

        // Reset with two ops in flight
        ready_mode = 0;
        settle(2);
        issue(2'b10, 32'h3F80_0000, 32'h0000_0000, 4'd7, mk(4'd7, 1'b1, 32'h0000_0000, 4'b0000));
        issue(2'b10, 32'hBF80_0000, 32'h7F80_0000, 4'd8, mk(4'd8, 1'b1, 32'hFF80_0000, 4'b0000));
        in_valid = 1'b0;
        check("inflight_before_rst", out_valid, 1'b1);
        rst = 1'b1;
        settle(1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sticky", sticky_flags, 4'b0000);
        check("midrst_out_result", out_result, 32'h0);
        check("midrst_out_flags", out_flags, 4'b0000);
        check("midrst_out_tag", out_tag, 4'h0);
        check("midrst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        ready_mode = 1;
        settle(2);
        check("post_midrst_out_valid", out_valid, 1'b0);
        check("post_midrst_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_special_case_unit.md
Name: fp_special_case_unit

Overview:
- Pipelined, parametrised FP special-case resolver for binary ops add/sub/mul/div; sits ahead of the arithmetic datapath.
- Classifies both operands (nan/inf/denormal/normal/zero); resolves every IEEE-754 special case (NaN, inf, signed zero, invalid, divide-by-zero) and delivers the final result. Otherwise signals that the main datapath must compute the result.
- Two-stage valid/ready pipeline with tag passthrough and sticky exception flags.

Parameters:
- EXP_WIDTH, 8, exponent field width (11 for double)
- MANT_WIDTH, 23, mantissa field width (52 for double)
- TAG_WIDTH, 4, width of opaque tag carried with each operation

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts operation this cycle
- in_op  in  2  00 add, 01 sub, 10 mul, 11 div
- in_a  in  EXP_WIDTH+MANT_WIDTH+1  operand A, [sign][exp][mant]
- in_b  in  EXP_WIDTH+MANT_WIDTH+1  operand B
- in_tag  in  TAG_WIDTH  opaque tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_special  out  1  1 = out_result is final; 0 = datapath must compute
- out_result  out  EXP_WIDTH+MANT_WIDTH+1  special-case result; 0 when out_special=0
- out_flags  out  4  {invalid, div_by_zero, nan_input, denorm_input}
- out_tag  out  TAG_WIDTH  tag of this result
- flags_clear  in  1  clears sticky_flags
- sticky_flags  out  4  OR of out_flags over all completed output handshakes

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high.
- Reset: stage valids=0, out_valid=0, out_special=0, out_result=0, out_flags=0, out_tag=0, sticky_flags=0. in_ready=0 while rst=1.
- Pipeline:
  - S1 registers operands, op, tag and the classification vectors.
  - S2 registers the resolved result, which drives the outputs.
  - adv2 = !out_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 & !rst (combinational).
  - Latency is exactly 2 cycles with no stall; throughput is 1 op/cycle.
  - Held outputs are stable while out_valid & !out_ready. Order is preserved; no drop or duplication.
- sub: B's sign is inverted before resolution. Flags use original encodings.
- Classification:
  - exp all-ones & mant≠0 = NaN; mant MSB=0 marks signaling.
  - exp all-ones & mant=0 = inf.
  - exp=0 & mant≠0 = denormal.
  - exp=0 & mant=0 = zero.
  - otherwise normal.
- Flags:
  - nan_input = either operand NaN.
  - denorm_input = either operand denormal.
  - invalid = any sNaN input, or any invalid combination below.
- Canonical NaN: sign 0, exp all-ones, mant MSB 1, rest 0.
- Resolution, first match wins; s = sign(A) xor sign(B):
  - any NaN -> canonical NaN, special.
  - add/sub:
    - inf + inf of opposite signs -> NaN, invalid.
    - any inf -> that inf.
    - zero + zero -> zero with sign = signA & signB.
    - zero + X -> X unchanged, special.
    - else not special.
  - mul:
    - inf*zero -> NaN, invalid.
    - inf involved -> inf with sign s.
    - zero involved -> zero with sign s.
    - else not special.
  - div:
    - inf/inf or 0/0 -> NaN, invalid.
    - inf/X -> inf with sign s.
    - X/inf -> zero with sign s.
    - nonzero finite/0 -> inf with sign s, div_by_zero.
    - 0/X -> zero with sign s.
    - else not special.
- Sticky: sticky_flags <= (flags_clear ? 0 : sticky_flags) | (out_valid & out_ready ? out_flags : 0). A handshake in the same cycle as flags_clear survives.
- rst mid-operation: all in-flight ops are discarded and outputs are 0 on the next cycle.

Optional Feature:
- FP_NAN_PROPAGATE_EN defined:
  - NaN result = first NaN operand (A before B), in its original encoding (B's original sign for sub).
  - The result is quieted by forcing mant MSB=1; payload and sign are kept.
- Not defined: every NaN result is the canonical NaN.

Test Plan:
- add A=0x7F800000, B=0xFF800000, tag 3 -> 2 cycles later: out_special=1, out_result=0x7FC00000, out_flags=1000, out_tag=3.
- div 0x3F800000/0x00000000 -> 0x7F800000, flags 0100. div 0xBF800000/0x00000000 -> 0xFF800000.
- mul 0x7F800001*0x3F800000 -> flags 1010, result 0x7FC00000; with FP_NAN_PROPAGATE_EN -> 0x7FC00001.
- sub 0x00000000-0x00000000 -> 0x00000000. add 0x80000000+0x80000000 -> 0x80000000. add 0x3F800000+0x40000000 -> out_special=0, result 0.
- Backpressure: tags 1,2,3 back-to-back with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts. Tag 3 is held until a slot frees; outputs come in order 1,2,3 with no loss or duplication.
- Sticky: complete an invalid op (sticky=1000), then flags_clear in the same cycle as a div_by_zero handshake -> sticky_flags=0100. rst asserted with 2 ops in flight -> out_valid=0 next cycle, sticky=0.
